// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle controller for a 32-bit logarithmic shifter.
// Applies one binary stage per clock in the order 16, 8, 4, 2, 1, so the ALU
// can share a narrow per-stage datapath instead of a full barrel shifter.
// Optional build macro: SHIFT_EARLY_EXIT_EN -- finish as soon as no lower
// shift-amount bits remain (shamt=0 goes straight to DONE). Results are the
// same either way; only the latency changes.

module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam int IDX_W = $clog2(SHAMT_W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] amt;
  logic [1:0]         opr;
  logic [IDX_W-1:0]   idx;

  logic [SHAMT_W-1:0] stage_bit;
  logic [WIDTH-1:0]   stage_out;
  logic               take;
  logic               last;
`ifdef SHIFT_EARLY_EXIT_EN
  logic [SHAMT_W-1:0] low_mask;
`endif

  // One shifter stage: shift acc by 2^idx when that shift-amount bit is set,
  // and decide whether this is the final stage of the request.
  always_comb begin
    stage_bit = SHAMT_W'(1) << idx;
    take      = |(amt & stage_bit);
    stage_out = acc;
    if (take) begin
      case (opr)
        2'b01:   stage_out = acc >> stage_bit;
        2'b10:   stage_out = $unsigned($signed(acc) >>> stage_bit);
        default: stage_out = acc << stage_bit;
      endcase
    end
`ifdef SHIFT_EARLY_EXIT_EN
    low_mask = stage_bit - SHAMT_W'(1);
    last     = (idx == '0) || ((amt & low_mask) == '0);
`else
    last     = (idx == '0);
`endif
  end

  // Sequencer FSM with registered handshake outputs and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
      amt    <= '0;
      opr    <= '0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc   <= data_in;
            amt   <= shamt;
            opr   <= op;
            idx   <= IDX_W'(SHAMT_W - 1);
            ready <= 1'b0;
            busy  <= 1'b1;
`ifdef SHIFT_EARLY_EXIT_EN
            if (shamt == '0) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= data_in;
            end else begin
              state <= SHIFT;
            end
`else
            state <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          acc <= stage_out;
          if (last) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= stage_out;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven, scoreboard-based bench for shift_sequencer.
// Expected latency follows SHIFT_EARLY_EXIT_EN when the bench is built with it.

module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int nvec;
  int nfail;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .data_in(data_in),
    .shamt  (shamt),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shifter built from whole-word operators.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d,
                                        input logic [4:0] s);
    case (o)
      2'b01:   return d >> s;
      2'b10:   return $unsigned($signed(d) >>> s);
      default: return d << s;
    endcase
  endfunction

  // Cycles from the accepting edge to the cycle in which done is high.
  function automatic int exp_latency(input logic [4:0] s);
`ifdef SHIFT_EARLY_EXIT_EN
    int lsb;
    if (s == 5'd0) return 1;
    lsb = 0;
    for (int b = 4; b >= 0; b--) if (s[b]) lsb = b;
    return 1 + (4 - lsb) + 1;
`else
    return 6;
`endif
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
    end
  endtask

  // Wait (bounded) for ready, then present one request for a single edge.
  // Returns at the falling edge of cycle 1 with start low again.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] d,
                               input logic [4:0] s, input bit push);
    int w;
    w = 0;
    while (ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    compare("ready before start", {31'b0, ready}, 32'd1);
    op      = o;
    data_in = d;
    shamt   = s;
    start   = 1'b1;
    if (push) begin
      exp_q.push_back(model(o, d, s));
      lat_q.push_back(exp_latency(s));
    end
    @(negedge clk);
    start   = 1'b0;
    op      = 2'($urandom_range(0, 3));
    data_in = $urandom;
    shamt   = 5'($urandom_range(0, 31));
  endtask

  // Wait (bounded) for done, check result, latency and handshake, then check
  // the cycle after the pulse. Returns at the falling edge of that cycle.
  task automatic checkOutput(input string name, input int start_cyc);
    int          cyc;
    bit          hs_bad;
    logic [31:0] exp;
    int          lat;
    cyc    = start_cyc;
    hs_bad = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      if (ready !== 1'b0 || busy !== 1'b1) hs_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (ready !== 1'b0 || busy !== 1'b1) hs_bad = 1'b1;
    compare({name, "/done seen"}, {31'b0, done}, 32'd1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      lat = lat_q.pop_front();
    end else begin
      exp = 32'hxxxx_xxxx;
      lat = -1;
    end
    compare({name, "/result"}, result, exp);
    compare({name, "/latency"}, 32'(cyc), 32'(lat));
    compare({name, "/busy-not-ready"}, {31'b0, hs_bad}, 32'd0);
    @(negedge clk);
    compare({name, "/done one cycle"}, {31'b0, done}, 32'd0);
    compare({name, "/ready back"}, {31'b0, ready}, 32'd1);
    compare({name, "/result held"}, result, exp);
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int ndone;
    int first_done;
    int second_done;

    nvec    = 0;
    nfail   = 0;
    rst     = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    data_in = 32'h0;
    shamt   = 5'd0;

    vecs.push_back('{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000});
    vecs.push_back('{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000});
    vecs.push_back('{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000});
    vecs.push_back('{2'b01, 32'hDEAD_BEEF, 5'd16, 32'h0000_DEAD});
    vecs.push_back('{2'b10, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF});
    vecs.push_back('{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000});
    vecs.push_back('{2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678});
    vecs.push_back('{2'b11, 32'hA5A5_A5A5, 5'd4,  32'h5A5A_5A50});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 5'd1,  32'h7FFF_FFFF});
    vecs.push_back('{2'b00, 32'h0000_ABCD, 5'd16, 32'hABCD_0000});
    vecs.push_back('{2'b10, 32'hF000_0000, 5'd3,  32'hFE00_0000});
    vecs.push_back('{2'b00, 32'h0000_0003, 5'd5,  32'h0000_0060});

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    compare("reset ready", {31'b0, ready}, 32'd1);
    compare("reset busy", {31'b0, busy}, 32'd0);
    compare("reset done", {31'b0, done}, 32'd0);
    compare("reset result", result, 32'd0);

    // Table vectors: check the hand-written expectations against the model
    // too, then run each through the DUT.
    for (int i = 0; i < vecs.size(); i++) begin
      compare($sformatf("table %0d model", i), model(vecs[i].op, vecs[i].data, vecs[i].shamt),
              vecs[i].exp);
      applyStimulus(vecs[i].op, vecs[i].data, vecs[i].shamt, 1'b1);
      exp_q[exp_q.size()-1] = vecs[i].exp;
      checkOutput($sformatf("table %0d", i), 1);
    end

    // Random vectors against the model.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 1'b1);
      checkOutput($sformatf("random %0d", i), 1);
    end

    // A start pulsed in cycle 3 of a busy operation is ignored.
    applyStimulus(2'b01, 32'hDEAD_BEEF, 5'd16, 1'b1);
    @(negedge clk);
    @(negedge clk);
    op      = 2'b00;
    data_in = 32'hFFFF_FFFF;
    shamt   = 5'd1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignored start", 4);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    compare("ignored start extra dones", 32'(ndone), 32'd0);
    compare("ignored start result kept", result, 32'h0000_DEAD);

    // Reset in cycle 3 aborts an SLL by 8 without a done pulse.
    applyStimulus(2'b00, 32'h0000_0F0F, 5'd8, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compare("abort ready", {31'b0, ready}, 32'd1);
    compare("abort busy", {31'b0, busy}, 32'd0);
    compare("abort done", {31'b0, done}, 32'd0);
    compare("abort result", result, 32'd0);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    compare("abort no done", 32'(ndone), 32'd0);
    applyStimulus(2'b00, 32'h0000_00FF, 5'd8, 1'b1);
    checkOutput("after abort", 1);

    // Back-to-back: start held high accepts a second request as soon as the
    // sequencer is ready again, sampling the operands present at that edge.
    op      = 2'b00;
    data_in = 32'h0000_0011;
    shamt   = 5'd4;
    start   = 1'b1;
    exp_q.push_back(32'h0000_0110);
    exp_q.push_back(32'h00F0_0000);
    @(negedge clk);
    op          = 2'b01;
    data_in     = 32'hF000_0000;
    shamt       = 5'd8;
    ndone       = 0;
    first_done  = 0;
    second_done = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (first_done > 0 && cyc == first_done + 2) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (first_done == 0) first_done = cyc;
        else if (second_done == 0) second_done = cyc;
        if (exp_q.size() > 0) compare($sformatf("back-to-back done %0d", ndone), result,
                                      exp_q.pop_front());
      end
      @(negedge clk);
    end
    start = 1'b0;
    compare("back-to-back done count", 32'(ndone), 32'd2);
    compare("back-to-back first latency", 32'(first_done), 32'(exp_latency(5'd4)));
    compare("back-to-back spacing", 32'(second_done - first_done), 32'(1 + exp_latency(5'd8)));
    exp_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
